pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer; the successor to the fixed-width, always-enabled stage registers between pipeline stages. It carries a DATA_W data word and a CTRL_W control word per entry and supports downstream stall, flush with bubble insertion, and a halt flag that closes the stage. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Because in_ready depends only on registered state, there is no combinational ready path across stages.

---
 rtl/pipe_skid_stage_if.sv | 30 +++
 rtl/pipe_skid_stage.sv | 75 +++++++
 tb/tb_pipe_skid_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream offer, downstream head entry and stage status.
// The master modport drives the stage, the slave modport is the stage itself.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_halt;
  logic              flush;
  logic              halted;
  logic [1:0]        count;

  modport master (
    output in_valid, in_data, in_ctrl, in_halt, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl, out_halt, halted, count
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_halt, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl, out_halt, halted, count
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer,
// flush with bubble insertion and a sticky halt that closes the input.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input logic              clk,
  input logic              rst,
  pipe_skid_stage_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              halt;
  } entry_t;

  entry_t head;
  entry_t skid;
  entry_t incoming;
  logic   head_valid;
  logic   skid_valid;
  logic   halted_q;
  logic   accept;
  logic   emit;

  // Ready comes from registered state only; rst gating keeps it low while held in reset.
  assign bus.in_ready = rst & ~skid_valid & ~halted_q;
  assign accept       = bus.in_valid & bus.in_ready;
  assign emit         = head_valid & bus.out_ready;
  assign incoming     = '{data: bus.in_data, ctrl: bus.in_ctrl, halt: bus.in_halt};

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head.data;
  assign bus.out_ctrl  = head_valid ? head.ctrl : '0;
  assign bus.out_halt  = head_valid & head.halt;
  assign bus.halted    = halted_q;
  assign bus.count     = {1'b0, head_valid} + {1'b0, skid_valid};

  // Skid only ever holds the entry behind head, so skid_valid implies head_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      skid       <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      halted_q   <= 1'b0;
    end else if (bus.flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (accept && bus.in_halt) begin
        halted_q <= 1'b1;
      end
      if (skid_valid) begin
        if (emit) begin
          head       <= skid;
          skid_valid <= 1'b0;
        end
      end else if (head_valid) begin
        if (accept && emit) begin
          head <= incoming;
        end else if (accept) begin
          skid       <= incoming;
          skid_valid <= 1'b1;
        end else if (emit) begin
          head_valid <= 1'b0;
        end
      end else if (accept) begin
        head       <= incoming;
        head_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed test-plan steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_pipe_skid_stage;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic        halt;
  } entry_t;

  entry_t      model_q[$];
  logic        model_halted = 1'b0;
  logic [31:0] model_last   = 32'h0;
  int          tests_run    = 0;
  int          failures     = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance model, check outputs after.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                               input logic [7:0] c, input logic h, input logic o,
                               input logic f);
    logic   exp_ready;
    logic   acc;
    logic   emi;
    entry_t e;
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.in_halt   = h;
    bus.out_ready = o;
    bus.flush     = f;
    #1;
    exp_ready = r && (model_q.size() < 2) && !model_halted;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    emi = (model_q.size() > 0) && o;
    @(posedge clk);
    #1;
    if (!r) begin
      model_q.delete();
      model_halted = 1'b0;
      model_last   = 32'h0;
    end else if (f) begin
      model_q.delete();
      model_halted = 1'b0;
    end else begin
      if (emi) void'(model_q.pop_front());
      if (acc) begin
        e.data = d;
        e.ctrl = c;
        e.halt = h;
        model_q.push_back(e);
        if (h) model_halted = 1'b1;
      end
    end
    if (model_q.size() > 0) model_last = model_q[0].data;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    checkOutput("out_data", bus.out_data, model_last);
    checkOutput("out_ctrl", 32'(bus.out_ctrl), (model_q.size() > 0) ? 32'(model_q[0].ctrl) : 32'h0);
    checkOutput("out_halt", 32'(bus.out_halt), (model_q.size() > 0) ? 32'(model_q[0].halt) : 32'h0);
    checkOutput("halted", 32'(bus.halted), 32'(model_halted));
    checkOutput("count", 32'(bus.count), 32'(model_q.size()));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_ctrl   = 8'h0;
    bus.in_halt   = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held for two cycles, with traffic offered that must be ignored.
    applyStimulus(1'b0, 1'b1, 32'hDEAD, 8'h3C, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    // Streaming at full throughput.
    applyStimulus(1'b1, 1'b1, 32'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h11, 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h12, 8'h03, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    // Stall fills the skid entry, then drain in order.
    applyStimulus(1'b1, 1'b1, 32'hA0, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hA1, 8'h12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hA2, 8'h13, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    // Bubble: control on the bus must not leak to the outputs.
    applyStimulus(1'b1, 1'b0, 32'h0, 8'hFF, 1'b0, 1'b1, 1'b0);
    checkOutput("bubble_ctrl", 32'(bus.out_ctrl), 32'h0);

    // Halt closes the input; the entry behind it is never taken.
    applyStimulus(1'b1, 1'b1, 32'h55, 8'h21, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_flag", 32'(bus.halted), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h56, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h56, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h56, 8'h22, 1'b0, 1'b1, 1'b0);

    // Flush with a full stage and an offered entry in the same cycle.
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hB0, 8'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB1, 8'h32, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h77, 8'h33, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_count", 32'(bus.count), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    // Reset while full and halted.
    applyStimulus(1'b1, 1'b1, 32'hC0, 8'h41, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hC1, 8'h42, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hC2, 8'h43, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_data", bus.out_data, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional halt, flush and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    1'($urandom_range(0, 3) != 0),
                    $urandom,
                    8'($urandom),
                    ($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
